ps2_packet_ctrl: RTL and testbench

//   Sequences the PS/2 mouse byte stream into 3-byte packets and delivers them downstream.
//   - Sync: byte 1 is recognised by in_byte[3]==1.
//   - Packets go out over a valid/ready handshake through a single-entry output register.
//   - Sits between the PS/2 byte receiver (which cannot be stalled) and the packet consumer.
//   - Counts dropped packets and flags framing errors.

---
 rtl/ps2_packet_ctrl_if.sv | 21 ++
 rtl/ps2_packet_ctrl.sv | 111 +++++++++++
 tb/tb_ps2_packet_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_packet_ctrl_if.sv
// Packet output bus between ps2_packet_ctrl and the packet consumer.
`timescale 1ns/1ps
interface ps2_packet_ctrl_if;
  logic [23:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;

  // Producer side (the packet controller)
  modport master (
    output pkt_data,
    output pkt_valid,
    input  pkt_ready
  );

  // Consumer side
  modport slave (
    input  pkt_data,
    input  pkt_valid,
    output pkt_ready
  );
endinterface

// File: rtl/ps2_packet_ctrl.sv
// ps2_packet_ctrl: frames the PS/2 mouse byte stream into 3-byte packets and
// hands them to a consumer through a single-entry valid/ready output register.
// Byte 1 of a packet is recognised by bit 3 being set.  Packets completed while
// the output register is still occupied are dropped and counted (saturating).
// Optional macro PS2_TIMEOUT_EN: abandon a partial packet after TIMEOUT_CYCLES
// idle cycles and report it on sync_err.
`timescale 1ns/1ps
module ps2_packet_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  ps2_packet_ctrl_if.master    pkt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 sync_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    BYTE1 = 2'd0,
    BYTE2 = 2'd1,
    BYTE3 = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  byte1;
  logic [7:0]  byte2;
  logic        out_free;
  logic        pop;
  logic        timeout_hit;

  // Output register can take a new packet if empty or being popped this edge
  assign pop      = pkt.pkt_valid & pkt.pkt_ready;
  assign out_free = ~pkt.pkt_valid | pkt.pkt_ready;
  assign busy     = (state != BYTE1);

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_cnt;

  // Expiry only counts when no byte arrives; an arriving byte always wins
  assign timeout_hit = ~in_valid & (state != BYTE1) &
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle cycles spent holding a partial packet
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (in_valid || (state == BYTE1) || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Packet framing FSM with registered output packet, drop counter and sync error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= BYTE1;
      byte1         <= '0;
      byte2         <= '0;
      pkt.pkt_data  <= '0;
      pkt.pkt_valid <= 1'b0;
      drop_cnt      <= '0;
      sync_err      <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (pop) begin
        pkt.pkt_valid <= 1'b0;
      end
      if (in_valid) begin
        case (state)
          BYTE1: begin
            if (in_byte[3]) begin
              byte1 <= in_byte;
              state <= BYTE2;
            end else begin
              sync_err <= 1'b1;
            end
          end
          BYTE2: begin
            byte2 <= in_byte;
            state <= BYTE3;
          end
          BYTE3: begin
            state <= BYTE1;
            if (out_free) begin
              // A completion on the same edge as a pop refills the register
              pkt.pkt_data  <= {byte1, byte2, in_byte};
              pkt.pkt_valid <= 1'b1;
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
            end
          end
          default: state <= BYTE1;
        endcase
      end else if (timeout_hit) begin
        state    <= BYTE1;
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Testbench for ps2_packet_ctrl: directed vector table, hand-written reset and
// timeout sequences, then randomized traffic checked against a packet-level model.
`timescale 1ns/1ps
module tb_ps2_packet_ctrl;

  localparam int unsigned T_CYC = 16;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic [CW-1:0] drop_cnt;
  logic          sync_err;
  logic          busy;

  ps2_packet_ctrl_if pkt_bus ();

  ps2_packet_ctrl #(.TIMEOUT_CYCLES(T_CYC), .CNT_W(CW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .pkt      (pkt_bus),
    .drop_cnt (drop_cnt),
    .sync_err (sync_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          v;
    logic [7:0]    b;
    logic          rdy;
    logic          e_valid;
    logic [23:0]   e_data;
    logic [CW-1:0] e_drop;
    logic          e_serr;
    logic          e_busy;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] b, logic rdy, logic ev,
                              logic [23:0] ed, logic [CW-1:0] edr, logic es, logic eb);
    vec_t r;
    r.v = v; r.b = b; r.rdy = rdy; r.e_valid = ev; r.e_data = ed;
    r.e_drop = edr; r.e_serr = es; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [23:0] ed,
                           input logic [CW-1:0] edr, input logic es, input logic eb);
    chk({tag, " pkt_valid"}, 32'(pkt_bus.pkt_valid), 32'(ev));
    chk({tag, " pkt_data"},  32'(pkt_bus.pkt_data),  32'(ed));
    chk({tag, " drop_cnt"},  32'(drop_cnt),          32'(edr));
    chk({tag, " sync_err"},  32'(sync_err),          32'(es));
    chk({tag, " busy"},      32'(busy),              32'(eb));
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle before sampling
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    in_valid = v;
    in_byte  = b;
    pkt_bus.pkt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- packet-level reference model ----------------
  logic [7:0]  m_part[$];
  logic        m_valid;
  logic [23:0] m_data;
  int          m_drop;
  logic        m_serr;
  int          m_idle;

  task automatic model_reset();
    m_part.delete();
    m_valid = 1'b0; m_data = '0; m_drop = 0; m_serr = 1'b0; m_idle = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b, input logic rdy);
    if (m_valid && rdy) m_valid = 1'b0;
    m_serr = 1'b0;
    if (v) begin
      m_idle = 0;
      if (m_part.size() == 0 && !b[3]) begin
        m_serr = 1'b1;
      end else begin
        m_part.push_back(b);
        if (m_part.size() == 3) begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = {m_part[0], m_part[1], m_part[2]};
          end else if (m_drop < (1 << CW) - 1) begin
            m_drop++;
          end
          m_part.delete();
        end
      end
    end else if (m_part.size() != 0) begin
`ifdef PS2_TIMEOUT_EN
      m_idle++;
      if (m_idle == int'(T_CYC)) begin
        m_part.delete();
        m_serr = 1'b1;
        m_idle = 0;
      end
`endif
    end
  endtask

  vec_t vecs[26];

  initial begin
    // Directed table: basic, resync, same-edge pop+load, backpressure/drop
    vecs[0]  = mk(1, 8'h08, 1, 0, 24'h000000, 0, 0, 1);
    vecs[1]  = mk(1, 8'h12, 1, 0, 24'h000000, 0, 0, 1);
    vecs[2]  = mk(1, 8'h34, 1, 1, 24'h081234, 0, 0, 0);
    vecs[3]  = mk(0, 8'h00, 1, 0, 24'h081234, 0, 0, 0);
    vecs[4]  = mk(1, 8'h00, 1, 0, 24'h081234, 0, 1, 0);
    vecs[5]  = mk(1, 8'h07, 1, 0, 24'h081234, 0, 1, 0);
    vecs[6]  = mk(1, 8'h0C, 1, 0, 24'h081234, 0, 0, 1);
    vecs[7]  = mk(1, 8'hAA, 1, 0, 24'h081234, 0, 0, 1);
    vecs[8]  = mk(1, 8'hBB, 1, 1, 24'h0CAABB, 0, 0, 0);
    vecs[9]  = mk(0, 8'h00, 1, 0, 24'h0CAABB, 0, 0, 0);
    vecs[10] = mk(1, 8'h08, 0, 0, 24'h0CAABB, 0, 0, 1);
    vecs[11] = mk(1, 8'h01, 0, 0, 24'h0CAABB, 0, 0, 1);
    vecs[12] = mk(1, 8'h02, 0, 1, 24'h080102, 0, 0, 0);
    vecs[13] = mk(1, 8'h09, 0, 1, 24'h080102, 0, 0, 1);
    vecs[14] = mk(1, 8'h05, 0, 1, 24'h080102, 0, 0, 1);
    vecs[15] = mk(1, 8'h06, 1, 1, 24'h090506, 0, 0, 0);
    vecs[16] = mk(0, 8'h00, 1, 0, 24'h090506, 0, 0, 0);
    vecs[17] = mk(1, 8'h08, 0, 0, 24'h090506, 0, 0, 1);
    vecs[18] = mk(1, 8'h01, 0, 0, 24'h090506, 0, 0, 1);
    vecs[19] = mk(1, 8'h02, 0, 1, 24'h080102, 0, 0, 0);
    vecs[20] = mk(1, 8'h09, 0, 1, 24'h080102, 0, 0, 1);
    vecs[21] = mk(1, 8'h03, 0, 1, 24'h080102, 0, 0, 1);
    vecs[22] = mk(1, 8'h04, 0, 1, 24'h080102, 1, 0, 0);
    vecs[23] = mk(0, 8'h00, 0, 1, 24'h080102, 1, 0, 0);
    vecs[24] = mk(0, 8'h00, 1, 0, 24'h080102, 1, 0, 0);
    vecs[25] = mk(0, 8'h00, 1, 0, 24'h080102, 1, 0, 0);

    resetn = 1'b0;
    in_valid = 1'b0;
    in_byte = '0;
    pkt_bus.pkt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_all("reset", 0, 24'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].b, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                vecs[i].e_drop, vecs[i].e_serr, vecs[i].e_busy);
    end

    // Async reset mid-packet with a packet held in the output register
    step(1, 8'h08, 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    check_all("pre_rst_held", 1, 24'h081122, 1, 0, 0);
    step(1, 8'h08, 0);
    step(1, 8'h01, 0);
    check_all("pre_rst_part", 1, 24'h081122, 1, 0, 1);
    in_valid = 1'b0;
    #3;
    resetn = 1'b0;
    #1;
    check_all("async_rst", 0, 24'h0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    step(0, 8'h00, 0);
    check_all("post_rst", 0, 24'h0, 0, 0, 0);
    step(1, 8'h08, 1);
    step(1, 8'h01, 1);
    step(1, 8'h02, 1);
    check_all("post_rst_pkt", 1, 24'h080102, 0, 0, 0);
    step(0, 8'h00, 1);
    check_all("post_rst_pop", 0, 24'h080102, 0, 0, 0);

    // Mid-packet idle: timeout when enabled, indefinite wait otherwise
    step(1, 8'h08, 1);
    check_all("to_b1", 0, 24'h080102, 0, 0, 1);
    for (int i = 1; i <= 20; i++) begin
      step(0, 8'h00, 1);
`ifdef PS2_TIMEOUT_EN
      check_all($sformatf("to_idle%0d", i), 0, 24'h080102, 0, (i == int'(T_CYC)), (i < int'(T_CYC)));
`else
      check_all($sformatf("to_idle%0d", i), 0, 24'h080102, 0, 0, 1);
`endif
    end
    step(1, 8'h08, 1);
    check_all("to_n1", 0, 24'h080102, 0, 0, 1);
`ifdef PS2_TIMEOUT_EN
    step(1, 8'h11, 1);
    check_all("to_n2", 0, 24'h080102, 0, 0, 1);
    step(1, 8'h22, 1);
    check_all("to_n3", 1, 24'h081122, 0, 0, 0);
`else
    step(1, 8'h11, 1);
    check_all("to_n2", 1, 24'h080811, 0, 0, 0);
    step(1, 8'h22, 1);
    check_all("to_n3", 0, 24'h080811, 0, 1, 0);
`endif
    step(0, 8'h00, 1);

    // Randomized traffic against the model, starting from a fresh reset
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      int unsigned pv, pr;
      logic v, r;
      logic [7:0] b;
      case (c / 1000)
        0:       begin pv = 60; pr = 70; end
        1:       begin pv = 70; pr = 5;  end
        2:       begin pv = 5;  pr = 50; end
        default: begin pv = 45; pr = 40; end
      endcase
      v = ($urandom_range(99) < pv);
      r = ($urandom_range(99) < pr);
      b = 8'($urandom);
      if ($urandom_range(99) < 80) b[3] = 1'b1;
      model_edge(v, b, r);
      step(v, b, r);
      check_all($sformatf("rnd%0d", c), m_valid, m_data, CW'(m_drop), m_serr, (m_part.size() != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
